// File: rtl/issue_pkg.sv
// Shared definitions for the operand issue stage: default widths, the
// per-stage bypass control layout and the counter saturation constant.
package issue_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int AREG_W_DEF = 5;

  // Control bits a forwarding stage presents alongside its dest index and data.
  typedef struct packed {
    logic valid;
    logic wen;
    logic data_ok;
  } byp_ctrl_t;

  localparam int BYP_CTRL_W = $bits(byp_ctrl_t);

  // Counters compare against the low CNT_W bits of this to stick at all-ones.
  localparam logic [63:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/operand_select.sv
// Resolves one source operand from the forwarding stages or the register file.
// The youngest matching stage wins; a match without data yet stalls the source.
module operand_select
  import issue_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int AREG_W  = AREG_W_DEF,
  parameter int NUM_BYP = 3
) (
  input  logic [AREG_W-1:0]         i_src_addr,
  input  logic                      i_src_use,
  input  logic [NUM_BYP-1:0]        i_byp_valid,
  input  logic [NUM_BYP-1:0]        i_byp_wen,
  input  logic [NUM_BYP*AREG_W-1:0] i_byp_addr,
  input  logic [NUM_BYP-1:0]        i_byp_data_ok,
  input  logic [NUM_BYP*XLEN-1:0]   i_byp_data,
  input  logic [XLEN-1:0]           i_rf_rdata,
  output logic                      o_ready,
  output logic [XLEN-1:0]           o_data
);

  byp_ctrl_t       w_ctrl;
  logic            w_hit;
  logic            w_hit_ok;
  logic [XLEN-1:0] w_hit_data;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    w_ctrl     = '0;
    w_hit      = 1'b0;
    w_hit_ok   = 1'b0;
    w_hit_data = '0;
    for (int j = NUM_BYP - 1; j >= 0; j--) begin
      w_ctrl = '{valid: i_byp_valid[j], wen: i_byp_wen[j], data_ok: i_byp_data_ok[j]};
      if (w_ctrl.valid && w_ctrl.wen &&
          (i_byp_addr[j*AREG_W +: AREG_W] == i_src_addr)) begin
        w_hit      = 1'b1;
        w_hit_ok   = w_ctrl.data_ok;
        w_hit_data = i_byp_data[j*XLEN +: XLEN];
      end
    end
  end

  // x0 and unused sources never stall, even when a stage claims to write r0.
  always_comb begin
    o_ready = 1'b1;
    o_data  = '0;
    if (i_src_use && (i_src_addr != '0)) begin
      if (w_hit) begin
        o_ready = w_hit_ok;
        if (w_hit_ok) o_data = w_hit_data;
      end else begin
        o_data = i_rf_rdata;
      end
    end
  end

endmodule

// File: rtl/operand_issue_stage.sv
// Decode/issue stage: main + skid holding registers, per-source operand
// forwarding, valid/ready issue handshake and saturating stall counters.
module operand_issue_stage
  import issue_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int AREG_W    = AREG_W_DEF,
  parameter int NUM_SRC   = 2,
  parameter int NUM_BYP   = 3,
  parameter int PAYLOAD_W = 128,
  parameter int CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [NUM_SRC*AREG_W-1:0] in_src_addr,
  input  logic [NUM_SRC-1:0]        in_src_use,
  output logic [NUM_SRC*AREG_W-1:0] rf_raddr,
  input  logic [NUM_SRC*XLEN-1:0]   rf_rdata,
  input  logic [NUM_BYP-1:0]        byp_valid,
  input  logic [NUM_BYP-1:0]        byp_wen,
  input  logic [NUM_BYP*AREG_W-1:0] byp_addr,
  input  logic [NUM_BYP-1:0]        byp_data_ok,
  input  logic [NUM_BYP*XLEN-1:0]   byp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [NUM_SRC*XLEN-1:0]   out_src_data,
  output logic [CNT_W-1:0]          hazard_cnt,
  output logic [CNT_W-1:0]          bp_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_ALL_ONES[CNT_W-1:0];

  logic                      r_main_valid;
  logic [PAYLOAD_W-1:0]      r_main_payload;
  logic [NUM_SRC*AREG_W-1:0] r_main_addr;
  logic [NUM_SRC-1:0]        r_main_use;
  logic                      r_skid_valid;
  logic [PAYLOAD_W-1:0]      r_skid_payload;
  logic [NUM_SRC*AREG_W-1:0] r_skid_addr;
  logic [NUM_SRC-1:0]        r_skid_use;
  logic                      r_in_ready;
  logic [CNT_W-1:0]          r_hazard_cnt;
  logic [CNT_W-1:0]          r_bp_cnt;

  logic                      w_nxt_main_valid;
  logic [PAYLOAD_W-1:0]      w_nxt_main_payload;
  logic [NUM_SRC*AREG_W-1:0] w_nxt_main_addr;
  logic [NUM_SRC-1:0]        w_nxt_main_use;
  logic                      w_nxt_skid_valid;
  logic [PAYLOAD_W-1:0]      w_nxt_skid_payload;
  logic [NUM_SRC*AREG_W-1:0] w_nxt_skid_addr;
  logic [NUM_SRC-1:0]        w_nxt_skid_use;

  logic [NUM_SRC-1:0]        w_src_ready;
  logic                      w_go;
  logic                      w_fire;
  logic                      w_in_hs;
  logic                      w_main_free;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    operand_select #(
      .XLEN    (XLEN),
      .AREG_W  (AREG_W),
      .NUM_BYP (NUM_BYP)
    ) u_sel (
      .i_src_addr    (r_main_addr[k*AREG_W +: AREG_W]),
      .i_src_use     (r_main_use[k]),
      .i_byp_valid   (byp_valid),
      .i_byp_wen     (byp_wen),
      .i_byp_addr    (byp_addr),
      .i_byp_data_ok (byp_data_ok),
      .i_byp_data    (byp_data),
      .i_rf_rdata    (rf_rdata[k*XLEN +: XLEN]),
      .o_ready       (w_src_ready[k]),
      .o_data        (out_src_data[k*XLEN +: XLEN])
    );
  end

  assign w_go        = &w_src_ready;
  assign w_fire      = r_main_valid & w_go & out_ready;
  assign w_in_hs     = in_valid & r_in_ready;
  assign w_main_free = ~r_main_valid | w_fire;

  // Flush wins over any load; an input handshaking in a flush cycle is dropped.
  always_comb begin
    w_nxt_main_valid   = r_main_valid;
    w_nxt_main_payload = r_main_payload;
    w_nxt_main_addr    = r_main_addr;
    w_nxt_main_use     = r_main_use;
    w_nxt_skid_valid   = r_skid_valid;
    w_nxt_skid_payload = r_skid_payload;
    w_nxt_skid_addr    = r_skid_addr;
    w_nxt_skid_use     = r_skid_use;
    if (flush) begin
      w_nxt_main_valid = 1'b0;
      w_nxt_skid_valid = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        w_nxt_main_valid   = 1'b1;
        w_nxt_main_payload = r_skid_payload;
        w_nxt_main_addr    = r_skid_addr;
        w_nxt_main_use     = r_skid_use;
        w_nxt_skid_valid   = 1'b0;
        if (w_in_hs) begin
          w_nxt_skid_valid   = 1'b1;
          w_nxt_skid_payload = in_payload;
          w_nxt_skid_addr    = in_src_addr;
          w_nxt_skid_use     = in_src_use;
        end
      end else begin
        w_nxt_main_valid   = w_in_hs;
        w_nxt_main_payload = in_payload;
        w_nxt_main_addr    = in_src_addr;
        w_nxt_main_use     = in_src_use;
      end
    end else if (w_in_hs) begin
      w_nxt_skid_valid   = 1'b1;
      w_nxt_skid_payload = in_payload;
      w_nxt_skid_addr    = in_src_addr;
      w_nxt_skid_use     = in_src_use;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid   <= 1'b0;
      r_main_payload <= '0;
      r_main_addr    <= '0;
      r_main_use     <= '0;
      r_skid_valid   <= 1'b0;
      r_skid_payload <= '0;
      r_skid_addr    <= '0;
      r_skid_use     <= '0;
      r_in_ready     <= 1'b1;
    end else begin
      r_main_valid   <= w_nxt_main_valid;
      r_main_payload <= w_nxt_main_payload;
      r_main_addr    <= w_nxt_main_addr;
      r_main_use     <= w_nxt_main_use;
      r_skid_valid   <= w_nxt_skid_valid;
      r_skid_payload <= w_nxt_skid_payload;
      r_skid_addr    <= w_nxt_skid_addr;
      r_skid_use     <= w_nxt_skid_use;
      r_in_ready     <= ~w_nxt_skid_valid;
    end
  end

  // Counters look at the current state only, so they keep counting through a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hazard_cnt <= '0;
      r_bp_cnt     <= '0;
    end else begin
      if (r_main_valid && !w_go && (r_hazard_cnt != CNT_MAX))
        r_hazard_cnt <= r_hazard_cnt + 1'b1;
      if (r_main_valid && w_go && !out_ready && (r_bp_cnt != CNT_MAX))
        r_bp_cnt <= r_bp_cnt + 1'b1;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_valid & w_go;
  assign out_payload = r_main_payload;
  assign rf_raddr    = r_main_addr;
  assign hazard_cnt  = r_hazard_cnt;
  assign bp_cnt      = r_bp_cnt;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Bench for operand_issue_stage: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the stage.
module tb_operand_issue_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_payload, out_payload;
  logic [9:0]  in_src_addr, rf_raddr;
  logic [1:0]  in_src_use;
  logic [63:0] rf_rdata, out_src_data;
  logic [2:0]  byp_valid, byp_wen, byp_data_ok;
  logic [14:0] byp_addr;
  logic [95:0] byp_data;
  logic [3:0]  hazard_cnt, bp_cnt;

  always #5 clk = ~clk;

  operand_issue_stage #(
    .XLEN(32), .AREG_W(5), .NUM_SRC(2), .NUM_BYP(3), .PAYLOAD_W(32), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_src_addr(in_src_addr), .in_src_use(in_src_use),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .byp_valid(byp_valid), .byp_wen(byp_wen), .byp_addr(byp_addr),
    .byp_data_ok(byp_data_ok), .byp_data(byp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_src_data(out_src_data), .hazard_cnt(hazard_cnt), .bp_cnt(bp_cnt)
  );

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return {8'hA0, 3'b000, a, 16'h1234};
  endfunction

  assign rf_rdata = {rf_val(rf_raddr[9:5]), rf_val(rf_raddr[4:0])};

  typedef struct packed {
    logic [31:0] pl;
    logic [9:0]  addr;
    logic [1:0]  src_use;
  } ent_t;

  ent_t        q[$];
  logic        m_in_ready;
  logic [3:0]  m_hz, m_bp;
  int          n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Operand rule: unused/x0 -> 0; youngest writing stage decides; else register file.
  function automatic void resolve(input logic [4:0] a, input logic u,
                                  output logic rdy, output logic [31:0] d);
    rdy = 1'b1;
    d   = '0;
    if (!u || a == 5'd0) return;
    for (int j = 0; j < 3; j++) begin
      if (byp_valid[j] && byp_wen[j] && byp_addr[j*5 +: 5] == a) begin
        rdy = byp_data_ok[j];
        d   = rdy ? byp_data[j*32 +: 32] : 32'h0;
        return;
      end
    end
    d = rf_val(a);
  endfunction

  task automatic step();
    ent_t        h;
    logic        r0, r1, go, hs, fire;
    logic [31:0] d0, d1;
    @(negedge clk);
    go = 1'b0;
    if (q.size() > 0) begin
      h = q[0];
      resolve(h.addr[4:0], h.src_use[0], r0, d0);
      resolve(h.addr[9:5], h.src_use[1], r1, d1);
      go = r0 & r1;
      check("out_valid", {63'b0, out_valid}, {63'b0, go});
      check("rf_raddr", {54'b0, rf_raddr}, {54'b0, h.addr});
      check("out_src_data", out_src_data, {d1, d0});
      if (go) check("out_payload", {32'b0, out_payload}, {32'b0, h.pl});
    end else begin
      check("out_valid_empty", {63'b0, out_valid}, 64'd0);
    end
    check("in_ready", {63'b0, in_ready}, {63'b0, m_in_ready});
    check("hazard_cnt", {60'b0, hazard_cnt}, {60'b0, m_hz});
    check("bp_cnt", {60'b0, bp_cnt}, {60'b0, m_bp});
    if (q.size() > 0) begin
      if (!go && m_hz != 4'hF) m_hz++;
      if (go && !out_ready && m_bp != 4'hF) m_bp++;
    end
    hs   = in_valid && m_in_ready;
    fire = (q.size() > 0) && go && out_ready;
    if (flush) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (hs) q.push_back('{pl: in_payload, addr: in_src_addr, src_use: in_src_use});
    end
    m_in_ready = (q.size() < 2);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_byp();
    byp_valid = '0; byp_wen = '0; byp_addr = '0; byp_data_ok = '0; byp_data = '0;
  endtask

  task automatic set_byp(input int j, input logic [4:0] a, input logic ok, input logic [31:0] d);
    byp_valid[j] = 1'b1;
    byp_wen[j] = 1'b1;
    byp_addr[j*5 +: 5] = a;
    byp_data_ok[j] = ok;
    byp_data[j*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_payload = '0; in_src_addr = '0; in_src_use = '0;
    clr_byp();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_payload", {32'b0, out_payload}, 64'd0);
    check("rst_out_src_data", out_src_data, 64'd0);
    check("rst_rf_raddr", {54'b0, rf_raddr}, 64'd0);
    check("rst_hazard_cnt", {60'b0, hazard_cnt}, 64'd0);
    check("rst_bp_cnt", {60'b0, bp_cnt}, 64'd0);
    reset = 1'b0;
    q.delete();
    m_in_ready = 1'b1; m_hz = '0; m_bp = '0;
    @(posedge clk); #1;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] a1, input logic [4:0] a0,
                          input logic [1:0] u);
    in_valid = v;
    in_payload = $urandom;
    in_src_addr = {a1, a0};
    in_src_use = u;
  endtask

  initial begin
    do_reset();

    // Hazard-free stream of 8 with EXE always ready.
    for (int i = 0; i < 8; i++) begin
      drive_in(1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 2'($urandom));
      step();
    end
    drive_in(1'b0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 3; i++) step();

    // Producer in stage 0 not ready for 3 cycles, then delivers.
    do_reset();
    set_byp(0, 5'd5, 1'b0, 32'h0BAD0BAD);
    drive_in(1'b1, 5'd0, 5'd5, 2'b01);
    step();
    drive_in(1'b0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 3; i++) step();
    check("hazard_cnt_3", {60'b0, hazard_cnt}, 64'd3);
    set_byp(0, 5'd5, 1'b1, 32'hDEADBEEF);
    #1;
    check("haz_issue_valid", {63'b0, out_valid}, 64'd1);
    check("haz_issue_data", out_src_data, {32'h0, 32'hDEADBEEF});
    step();
    clr_byp();
    step();

    // Youngest stage wins; r0 claimed by a stage never stalls.
    set_byp(0, 5'd7, 1'b1, 32'h11);
    set_byp(1, 5'd0, 1'b0, 32'h99);
    set_byp(2, 5'd7, 1'b1, 32'h22);
    drive_in(1'b1, 5'd0, 5'd7, 2'b11);
    step();
    drive_in(1'b0, 5'd0, 5'd0, 2'b00);
    #1;
    check("prio_valid", {63'b0, out_valid}, 64'd1);
    check("prio_data", out_src_data, {32'h0, 32'h11});
    step();
    clr_byp();

    // Backpressure: skid fills, in_ready drops, order kept afterwards.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, 5'd3, 5'd4, 2'b11);
      step();
    end
    check("bp_cnt_4", {60'b0, bp_cnt}, 64'd4);
    check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_in(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'($urandom));
      step();
    end
    drive_in(1'b0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 4; i++) step();

    // Flush with main and skid full and a new input offered.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_in(1'b1, 5'd1, 5'd2, 2'b11);
      step();
    end
    drive_in(1'b1, 5'd1, 5'd2, 2'b11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_in(1'b0, 5'd0, 5'd0, 2'b00);
    out_ready = 1'b1;
    #1;
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    for (int i = 0; i < 4; i++) step();

    // Long stall saturates the 4-bit hazard counter.
    do_reset();
    set_byp(0, 5'd5, 1'b0, 32'h0);
    drive_in(1'b1, 5'd0, 5'd5, 2'b01);
    step();
    drive_in(1'b0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 20; i++) step();
    check("hazard_cnt_sat", {60'b0, hazard_cnt}, 64'd15);
    clr_byp();
    step();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 2'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      byp_valid = 3'($urandom);
      byp_wen = 3'($urandom);
      byp_data_ok = 3'($urandom);
      for (int j = 0; j < 3; j++) begin
        byp_addr[j*5 +: 5] = 5'($urandom_range(0, 7));
        byp_data[j*32 +: 32] = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
